// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operation encodings and default datapath widths.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  typedef enum logic [1:0] {
    ALU   = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10,
    NOP   = 2'b11
  } op_e;

  // Only ALU results and loads produce a register write.
  function automatic logic op_writes_reg(op_e op);
    return (op == ALU) || (op == LOAD);
  endfunction

endpackage

// File: rtl/load_hold.sv
// Captures the load word on the first writeback-stall cycle, because the memory
// address moves on with M1 and rdata no longer belongs to the stalled load.
module load_hold #(
  parameter int DW = cpu_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          clear,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data
);

  logic          hold_valid_reg;
  logic [DW-1:0] hold_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (clear) begin
      hold_valid_reg <= 1'b0;
    end else if (capture && !hold_valid_reg) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= rdata;
    end
  end

  assign data = hold_valid_reg ? hold_data_reg : rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: M1 drives the synchronous data memory port,
// M2 presents the finished result to writeback through valid/ready.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_sdata,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  output logic          dwe,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RW-1:0] wb_rd,
  output logic          wb_we,
  output logic [DW-1:0] wb_data
);

  logic          m1_valid_reg;
  op_e           m1_op_reg;
  logic [DW-1:0] m1_alu_reg;
  logic [DW-1:0] m1_sdata_reg;
  logic [RW-1:0] m1_rd_reg;
  logic          m1_we_reg;

  logic          m2_valid_reg;
  op_e           m2_op_reg;
  logic [DW-1:0] m2_alu_reg;
  logic [RW-1:0] m2_rd_reg;
  logic          m2_we_reg;

  logic          m1_fire;
  logic          m2_accept;
  logic          hold_capture;
  logic [DW-1:0] load_word;

  assign m1_fire      = m1_valid_reg & (!m2_valid_reg | wb_ready);
  assign m2_accept    = m2_valid_reg & wb_ready;
  assign hold_capture = m2_valid_reg & (m2_op_reg == LOAD) & !wb_ready;
  assign in_ready     = !m1_valid_reg | m1_fire;

  // A store writes only on the edge it leaves M1, so stalls never repeat it.
  assign dwe   = m1_fire & (m1_op_reg == STORE) & !rst;
  assign addr  = m1_alu_reg[AW-1:0];
  assign wdata = m1_sdata_reg;

  assign wb_valid = m2_valid_reg;
  assign wb_rd    = m2_rd_reg;
  assign wb_we    = m2_we_reg;

  always_comb begin
    wb_data = '0;
    case (m2_op_reg)
      ALU:     wb_data = m2_alu_reg;
      LOAD:    wb_data = load_word;
      default: wb_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1_valid_reg <= 1'b0;
      m1_op_reg    <= ALU;
      m1_alu_reg   <= '0;
      m1_sdata_reg <= '0;
      m1_rd_reg    <= '0;
      m1_we_reg    <= 1'b0;
      m2_valid_reg <= 1'b0;
      m2_op_reg    <= ALU;
      m2_alu_reg   <= '0;
      m2_rd_reg    <= '0;
      m2_we_reg    <= 1'b0;
    end else begin
      if (in_ready) begin
        m1_valid_reg <= in_valid;
        if (in_valid) begin
          m1_op_reg    <= op_e'(in_op);
          m1_alu_reg   <= in_alu;
          m1_sdata_reg <= in_sdata;
          m1_rd_reg    <= in_rd;
          m1_we_reg    <= in_we;
        end
      end
      if (m1_fire) begin
        m2_valid_reg <= 1'b1;
        m2_op_reg    <= m1_op_reg;
        m2_alu_reg   <= m1_alu_reg;
        m2_rd_reg    <= m1_rd_reg;
        m2_we_reg    <= m1_we_reg & op_writes_reg(m1_op_reg);
      end else if (m2_accept) begin
        m2_valid_reg <= 1'b0;
      end
    end
  end

  load_hold #(.DW(DW)) u_load_hold (
    .clk     (clk),
    .rst     (rst),
    .capture (hold_capture),
    .clear   (m2_accept),
    .rdata   (rdata),
    .data    (load_word)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: behavioural data memory, an in-order result
// scoreboard checked at every writeback handshake, and literal spot checks.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;
  localparam int RW = RW_DEF;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_sdata;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          dwe;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic          wb_we;
  logic [DW-1:0] wb_data;

  mem_stage #(.AW(AW), .DW(DW), .RW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_alu   (in_alu),
    .in_sdata (in_sdata),
    .in_rd    (in_rd),
    .in_we    (in_we),
    .dwe      (dwe),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we),
    .wb_data  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem: synchronous read, written only by dwe; image loaded once at time 0.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (dwe) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] committed [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 16'h000a;
    mem[5] = 16'h000b;
    mem[9] = 16'h000c;
    model_mem = mem;
    committed = mem;
    rdata = '0;
  end

  typedef struct packed {
    logic [RW-1:0] rd;
    logic          we;
    logic [DW-1:0] data;
    logic          is_store;
    logic [7:0]    maddr;
    logic [DW-1:0] sdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int dwe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Scoreboard: results retire in issue order; a load sees every earlier store.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (rst) begin
      exp_q.delete();
      model_mem  = committed;
      prev_stall = 1'b0;
    end else begin
      if (dwe) dwe_cnt++;
      if (prev_stall) begin
        check("stall_valid", {31'b0, wb_valid}, 32'd1);
        check("stall_data", {16'b0, wb_data}, {16'b0, prev_data});
      end
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL wb_unexpected: got result rd=%0d data=0x%0h, required no result", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", {29'b0, wb_rd}, {29'b0, e.rd});
          check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
          check("wb_data", {16'b0, wb_data}, {16'b0, e.data});
          if (e.is_store) committed[e.maddr] = e.sdata;
        end
      end
      if (in_valid && in_ready) begin
        n = '0;
        n.rd    = in_rd;
        n.maddr = in_alu[7:0];
        case (op_e'(in_op))
          ALU:   begin n.we = in_we; n.data = in_alu; end
          LOAD:  begin n.we = in_we; n.data = model_mem[in_alu[7:0]]; end
          STORE: begin
            n.is_store = 1'b1;
            n.sdata    = in_sdata;
            model_mem[in_alu[7:0]] = in_sdata;
          end
          default: ;
        endcase
        exp_q.push_back(n);
      end
      prev_stall = wb_valid && !wb_ready;
      prev_data  = wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e op, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [RW-1:0] rd, input logic we);
    in_valid = 1'b1;
    in_op    = op;
    in_alu   = alu;
    in_sdata = sd;
    in_rd    = rd;
    in_we    = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = NOP;
    in_alu   = '0;
    in_sdata = '0;
    in_rd    = '0;
    in_we    = 1'b0;
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    wb_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_dwe", {31'b0, dwe}, 32'd0);
    check("rst_addr", {24'b0, addr}, 32'd0);
    check("rst_wdata", {16'b0, wdata}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_rd", {29'b0, wb_rd}, 32'd0);
    check("rst_wb_we", {31'b0, wb_we}, 32'd0);
    check("rst_wb_data", {16'b0, wb_data}, 32'd0);
    tick();
    rst = 1'b0;

    // Back-to-back loads, one result per cycle.
    drive(LOAD, 16'h0001, 16'h0, 3'd1, 1'b1); tick();
    drive(LOAD, 16'h0005, 16'h0, 3'd2, 1'b1); tick();
    drive(LOAD, 16'h0009, 16'h0, 3'd3, 1'b1);
    @(negedge clk);
    check("b2b_valid0", {31'b0, wb_valid}, 32'd1);
    check("b2b_data0", {16'b0, wb_data}, 32'h000a);
    tick(); idle();
    @(negedge clk);
    check("b2b_data1", {16'b0, wb_data}, 32'h000b);
    tick();
    @(negedge clk);
    check("b2b_data2", {16'b0, wb_data}, 32'h000c);
    tick();

    // Store then dependent load on the next cycle.
    c0 = dwe_cnt;
    drive(STORE, 16'h0005, 16'h1234, 3'd0, 1'b0); tick();
    drive(LOAD, 16'h0005, 16'h0, 3'd1, 1'b1); tick();
    idle(); tick();
    @(negedge clk);
    check("st_ld_data", {16'b0, wb_data}, 32'h1234);
    check("st_ld_rd", {29'b0, wb_rd}, 32'd1);
    tick(); tick();
    check("st_ld_dwe_count", dwe_cnt - c0, 32'd1);

    // Load held in M2 across a 4-cycle writeback stall.
    drive(LOAD, 16'h0009, 16'h0, 3'd2, 1'b1); tick();
    drive(LOAD, 16'h0001, 16'h0, 3'd3, 1'b1); wb_ready = 1'b0; tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_data", {16'b0, wb_data}, 32'h000c);
      if (i == 0) check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("hold_last", {16'b0, wb_data}, 32'h000c);
    tick();
    @(negedge clk);
    check("hold_next", {16'b0, wb_data}, 32'h000a);
    tick();

    // Store to wrapped address stalled in M1 behind an ALU result.
    wb_ready = 1'b0;
    drive(ALU, 16'h0042, 16'h0, 3'd2, 1'b1); tick();
    drive(STORE, 16'h0105, 16'h5a5a, 3'd0, 1'b0); tick();
    idle();
    c0 = dwe_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_stall_addr", {24'b0, addr}, 32'h05);
      check("st_stall_dwe", {31'b0, dwe}, 32'd0);
      check("st_stall_wdata", {16'b0, wdata}, 32'h5a5a);
      tick();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("st_release_dwe", {31'b0, dwe}, 32'd1);
    tick(); tick();
    check("st_stall_dwe_count", dwe_cnt - c0, 32'd1);
    drive(LOAD, 16'h0005, 16'h0, 3'd4, 1'b1); tick();
    idle(); tick();
    @(negedge clk);
    check("st_wrap_load", {16'b0, wb_data}, 32'h5a5a);
    tick();

    // Reset while a store sits in M1: the write is dropped.
    drive(STORE, 16'h0009, 16'hdead, 3'd0, 1'b0); tick();
    idle(); rst = 1'b1;
    @(negedge clk);
    check("rst_st_dwe", {31'b0, dwe}, 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_st_wb_valid", {31'b0, wb_valid}, 32'd0);
    tick();
    drive(LOAD, 16'h0009, 16'h0, 3'd5, 1'b1); tick();
    idle(); tick();
    @(negedge clk);
    check("rst_st_mem", {16'b0, wb_data}, 32'h000c);
    tick();

    // ALU result, then NOP that must not write a register.
    drive(ALU, 16'hbeef, 16'h0, 3'd3, 1'b1); tick();
    drive(NOP, 16'h0077, 16'h0, 3'd4, 1'b1); tick();
    idle();
    @(negedge clk);
    check("alu_data", {16'b0, wb_data}, 32'hbeef);
    check("alu_rd", {29'b0, wb_rd}, 32'd3);
    check("alu_we", {31'b0, wb_we}, 32'd1);
    tick();
    @(negedge clk);
    check("nop_we", {31'b0, wb_we}, 32'd0);
    check("nop_data", {16'b0, wb_data}, 32'd0);
    tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_queue", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
